mem_port_arbiter: RTL and testbench

- Shares the core's single 64-bit memory port between two requesters: instruction fetch (IF, read-only, 32-bit instructions) and load/store unit (LS, 64-bit read/write).
- Sits between the fetch and LSU stages and the external memory interface.
- LS has fixed priority, with an anti-starvation limit for fetch.
- Handles fetch alignment checks and a memory-response timeout so a hung memory cannot stall the pipeline forever.

---
 rtl/mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one 64-bit memory port between instruction fetch (IF, read-only,
// 32-bit instructions) and the load/store unit (LS, 64-bit read/write).
// LS has fixed priority. An anti-starvation streak counter forces IF to win
// after STARVE_LIMIT consecutive LS grants taken while IF was waiting. A
// response timeout aborts a memory access that never sees mem_ack.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   if_req/if_addr      : fetch request and byte address (held until if_ack)
//   if_rdata/if_ack/if_err : fetch response, valid for one cycle with if_ack
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wstrb : load/store request (held until ls_ack)
//   ls_rdata/ls_ack/ls_err : load/store response, valid for one cycle with ls_ack
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : memory request, stable until ack/timeout
//   mem_rdata/mem_ack   : memory response (mem_ack is a one-cycle pulse)
//   busy                : high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wstrb,
    output logic [63:0] ls_rdata,
    output logic        ls_ack,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MEM_IF = 2'd1;
    localparam logic [1:0] ST_MEM_LS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    // The access is abandoned at the end of the TIMEOUT_CYCLES-th memory cycle.
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q,     state_d;
    logic [SW-1:0] streak_q,    streak_d;
    logic [TW-1:0] tmo_q,       tmo_d;
    logic          if_hi_q,     if_hi_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [63:0]   mem_addr_q,  mem_addr_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]    mem_wstrb_q, mem_wstrb_d;
    logic          if_ack_q,    if_ack_d;
    logic          if_err_q,    if_err_d;
    logic [31:0]   if_rdata_q,  if_rdata_d;
    logic          ls_ack_q,    ls_ack_d;
    logic          ls_err_q,    ls_err_d;
    logic [63:0]   ls_rdata_q,  ls_rdata_d;
    logic          busy_q,      busy_d;

    logic          grant_ls;
    logic          grant_if;

    // Arbitration decision, only acted on in IDLE.
    always_comb begin
        grant_ls = ls_req & (~if_req | (streak_q != STREAK_MAX));
        grant_if = if_req & ~grant_ls;
    end

    // Next-state and next-output computation for the whole arbiter.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        if_hi_d     = if_hi_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        // Response outputs are pulses: zero unless entering RESP this edge.
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = 32'd0;
        ls_ack_d    = 1'b0;
        ls_err_d    = 1'b0;
        ls_rdata_d  = 64'd0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (grant_ls) begin
                    if (if_req) begin
                        if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + SW'(1'b1);
                        end else begin
                            streak_d = streak_q;
                        end
                    end else begin
                        streak_d = '0;
                    end
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    mem_wstrb_d = ls_we ? ls_wstrb : 8'h00;
                    state_d     = ST_MEM_LS;
                end else if (grant_if) begin
                    streak_d = '0;
                    if_hi_d  = if_addr[2];
                    if (if_addr[1:0] != 2'b00) begin
                        // Misaligned fetch never reaches memory.
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {if_addr[63:3], 3'b000};
                        mem_wdata_d = 64'd0;
                        mem_wstrb_d = 8'h00;
                        state_d     = ST_MEM_IF;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_IF, ST_MEM_LS: begin
                if (mem_ack) begin
                    // An ack on the final timeout cycle still counts as success.
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ST_RESP;
                    if (state_q == ST_MEM_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = if_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = mem_rdata;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ST_RESP;
                    if (state_q == ST_MEM_IF) begin
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                    end else begin
                        ls_ack_d = 1'b1;
                        ls_err_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1'b1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                tmo_d     = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            tmo_q       <= '0;
            if_hi_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_wstrb_q <= 8'h00;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= 32'd0;
            ls_ack_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= 64'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            if_hi_q     <= if_hi_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            ls_ack_q    <= ls_ack_d;
            ls_err_q    <= ls_err_d;
            ls_rdata_q  <= ls_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_ack    = ls_ack_q;
    assign ls_err    = ls_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack, if_err;
    logic        ls_req, ls_we;
    logic [63:0] ls_addr, ls_wdata;
    logic [7:0]  ls_wstrb;
    logic [63:0] ls_rdata;
    logic        ls_ack, ls_err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
        .ls_rdata(ls_rdata), .ls_ack(ls_ack), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b0; if_addr = 64'd0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = 64'd0; ls_wdata = 64'd0; ls_wstrb = 8'h00; mem_rdata = 64'd0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, busy, if_ack, if_err, ls_ack, ls_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl got=%b want=0000000", {mem_req, mem_we, busy, if_ack, if_err, ls_ack, ls_err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata} !== 232'd0) begin
            n_fail++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, mem_wstrb, if_rdata, ls_rdata});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle got=%b want=00", {busy, mem_req});
        end
    endtask

    task automatic test_if_read();
        if_req = 1'b1; if_addr = 64'h1004;
        @(negedge clk);
        n_checks++;
        if ({mem_req, busy, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b1, 1'b0, 64'h1000, 8'h00}) begin
            n_fail++; $display("FAIL if_read_mem got req=%b we=%b addr=%h strb=%h want 1 0 1000 00", mem_req, mem_we, mem_addr, mem_wstrb);
        end
        mem_ack = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        n_checks++;
        if ({if_ack, if_err, ls_ack, mem_req, if_rdata} !== {4'b1000, 32'hAAAA_BBBB}) begin
            n_fail++; $display("FAIL if_read_resp got ack=%b err=%b lsack=%b req=%b data=%h want 1 0 0 0 aaaabbbb", if_ack, if_err, ls_ack, mem_req, if_rdata);
        end
        mem_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_ack, busy} !== 2'b00) begin
            n_fail++; $display("FAIL if_read_idle got=%b want=00", {if_ack, busy});
        end
    endtask

    task automatic test_ls_store();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h2000; ls_wdata = 64'h1122334455667788; ls_wstrb = 8'h0F;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ls_ack} !== {2'b11, 64'h2000, 64'h1122334455667788, 8'h0F, 1'b0}) begin
                n_fail++; $display("FAIL ls_store_stable cyc=%0d got req=%b we=%b addr=%h wd=%h st=%h", i, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
            end
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({ls_ack, ls_err, if_ack, mem_req} !== 4'b1000) begin
            n_fail++; $display("FAIL ls_store_ack got=%b want=1000", {ls_ack, ls_err, if_ack, mem_req});
        end
        mem_ack = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ls_ack, busy} !== 2'b00) begin
            n_fail++; $display("FAIL ls_store_idle got=%b want=00", {ls_ack, busy});
        end
    endtask

    task automatic test_starvation();
        bit g[6];
        int ng = 0;
        logic prev = 1'b0;
        if_req = 1'b1; if_addr = 64'h1000;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h3000; ls_wdata = 64'hFEED; ls_wstrb = 8'hFF;
        for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
            @(negedge clk);
            if (mem_req && !prev) begin
                g[ng] = (mem_addr == 64'h3000);
                ng++;
                mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
            end else begin
                mem_ack = 1'b0;
            end
            prev = mem_req;
            if (ng == 6) begin
                if_req = 1'b0; ls_req = 1'b0;
            end
        end
        @(negedge clk); mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ng != 6) begin
            n_fail++; $display("FAIL starve_grants got=%0d want=6 (cycle budget)", ng);
        end
        for (int i = 0; i < ng; i++) begin
            n_checks++;
            if (g[i] != (i != 4)) begin
                n_fail++; $display("FAIL starve_order grant=%0d got_ls=%0b want_ls=%0b", i, g[i], (i != 4));
            end
        end
    endtask

    task automatic test_misaligned();
        if_req = 1'b1; if_addr = 64'h1002;
        @(negedge clk);
        n_checks++;
        if ({mem_req, if_ack, if_err, ls_ack, if_rdata} !== {4'b0110, 32'd0}) begin
            n_fail++; $display("FAIL misalign_resp got req=%b ack=%b err=%b lsack=%b data=%h want 0 1 1 0 0", mem_req, if_ack, if_err, ls_ack, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, if_ack, busy} !== 3'b000) begin
            n_fail++; $display("FAIL misalign_idle got=%b want=000", {mem_req, if_ack, busy});
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h4000; ls_wstrb = 8'hFF;
        @(negedge clk);
        n_checks++;
        if ({mem_we, mem_wstrb} !== 9'd0) begin
            n_fail++; $display("FAIL load_strb got we=%b strb=%h want 0 00", mem_we, mem_wstrb);
        end
        while (mem_req && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        n_checks++;
        if (hi != TMO) begin
            n_fail++; $display("FAIL timeout_len got=%0d want=%0d", hi, TMO);
        end
        n_checks++;
        if ({ls_ack, ls_err, ls_rdata} !== {2'b11, 64'd0}) begin
            n_fail++; $display("FAIL timeout_resp got ack=%b err=%b data=%h want 1 1 0", ls_ack, ls_err, ls_rdata);
        end
        ls_req = 1'b0;
        @(negedge clk);
        ls_req = 1'b1;
        @(negedge clk);
        repeat (TMO - 1) @(negedge clk);
        n_checks++;
        if ({mem_req, ls_ack} !== 2'b10) begin
            n_fail++; $display("FAIL timeout_lastcyc got=%b want=10", {mem_req, ls_ack});
        end
        mem_ack = 1'b1; mem_rdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        n_checks++;
        if ({ls_ack, ls_err, ls_rdata} !== {2'b10, 64'h0123456789ABCDEF}) begin
            n_fail++; $display("FAIL timeout_race got ack=%b err=%b data=%h want 1 0 0123456789abcdef", ls_ack, ls_err, ls_rdata);
        end
        mem_ack = 1'b0; ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h5000;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_req got=%b want=1", mem_req);
        end
        ls_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_req, busy, ls_ack} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_abort got=%b want=000", {mem_req, busy, ls_ack});
        end
        reset = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ls_ack || if_ack || busy) seen = 1'b1;
        end
        mem_ack = 1'b0;
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL rstmid_noack got=1 want=0");
        end
        if_req = 1'b1; if_addr = 64'h1008;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 64'h1008}) begin
            n_fail++; $display("FAIL rstmid_fetch got req=%b addr=%h want 1 1008", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF_12345678;
        @(negedge clk);
        n_checks++;
        if ({if_ack, if_err, if_rdata} !== {2'b10, 32'h12345678}) begin
            n_fail++; $display("FAIL rstmid_fetch_resp got ack=%b err=%b data=%h want 1 0 12345678", if_ack, if_err, if_rdata);
        end
        mem_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);
    endtask

    // Randomized traffic against a transaction-level model: phase 0 = idle,
    // 1 = memory access outstanding, 2 = response cycle.
    task automatic test_random(input int ncyc);
        int phase = 0, owner = 0, streak = 0, mcnt = 0, wtarget = 0;
        bit ifp = 1'b0, lsp = 1'b0, hi = 1'b0;
        logic [63:0] e_addr = 64'd0, e_wdata = 64'd0, e_rdata = 64'd0;
        logic e_we = 1'b0, e_err = 1'b0;
        logic [7:0] e_wstrb = 8'h00;
        reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            n_checks++;
            if ({busy, mem_req} !== {phase != 0, phase == 1}) begin
                n_fail++; $display("FAIL rnd_ctrl cyc=%0d got busy/req=%b%b want=%b%b", c, busy, mem_req, phase != 0, phase == 1);
            end
            if (phase == 1) begin
                n_checks++;
                if ({mem_addr, mem_we, mem_wstrb} !== {e_addr, e_we, e_wstrb} || (owner == 1 && mem_wdata !== e_wdata)) begin
                    n_fail++; $display("FAIL rnd_mem cyc=%0d got %h %b %h %h want %h %b %h %h", c, mem_addr, mem_we, mem_wstrb, mem_wdata, e_addr, e_we, e_wstrb, e_wdata);
                end
            end
            n_checks++;
            if ({if_ack, ls_ack} !== {phase == 2 && owner == 0, phase == 2 && owner == 1}) begin
                n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b%b want=%b%b", c, if_ack, ls_ack, phase == 2 && owner == 0, phase == 2 && owner == 1);
            end
            if (phase == 2) begin
                n_checks++;
                if (owner == 0 ? ({if_err, if_rdata} !== {e_err, e_rdata[31:0]}) : ({ls_err, ls_rdata} !== {e_err, e_rdata})) begin
                    n_fail++; $display("FAIL rnd_resp cyc=%0d owner=%0d got if=%b/%h ls=%b/%h want %b/%h", c, owner, if_err, if_rdata, ls_err, ls_rdata, e_err, e_rdata);
                end
                if (owner == 0) ifp = 1'b0; else lsp = 1'b0;
            end
            // Requesters: hold until acked, sometimes re-request immediately.
            if (!ifp && $urandom_range(2) == 0) begin
                ifp = 1'b1;
                if_addr = {$urandom, $urandom};
                if ($urandom_range(3) != 0) if_addr[1:0] = 2'b00;
            end
            if (!lsp && $urandom_range(2) == 0) begin
                lsp = 1'b1;
                ls_we = 1'($urandom_range(1));
                ls_addr = {$urandom, $urandom[31:3], 3'b000};
                ls_wdata = {$urandom, $urandom};
                ls_wstrb = 8'($urandom);
            end
            if_req = ifp; ls_req = lsp;
            // Memory: acks after wtarget wait cycles; stray acks elsewhere.
            mem_rdata = {$urandom, $urandom};
            if (phase == 1) mem_ack = (mcnt == wtarget);
            else mem_ack = ($urandom_range(4) == 0);
            case (phase)
                0: begin
                    if (ls_req && (!if_req || streak < LIMIT)) begin
                        streak = if_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
                        owner = 1; phase = 1;
                        e_addr = ls_addr; e_we = ls_we; e_wdata = ls_wdata;
                        e_wstrb = ls_we ? ls_wstrb : 8'h00;
                    end else if (if_req) begin
                        streak = 0; owner = 0; hi = if_addr[2];
                        if (if_addr[1:0] != 2'b00) begin
                            phase = 2; e_err = 1'b1; e_rdata = 64'd0;
                        end else begin
                            phase = 1; e_addr = {if_addr[63:3], 3'b000}; e_we = 1'b0; e_wstrb = 8'h00;
                        end
                    end
                    mcnt = 0; wtarget = $urandom_range(9);
                end
                1: begin
                    if (mem_ack) begin
                        phase = 2; e_err = 1'b0;
                        e_rdata = (owner == 1) ? mem_rdata : {32'd0, hi ? mem_rdata[63:32] : mem_rdata[31:0]};
                    end else if (mcnt == TMO - 1) begin
                        phase = 2; e_err = 1'b1; e_rdata = 64'd0;
                    end else begin
                        mcnt++;
                    end
                end
                default: phase = 0;
            endcase
            @(negedge clk);
        end
        if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_ls_store();
        test_starvation();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random(2000);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
